game_phase_sequencer: RTL and testbench

//  Top-level game-flow controller for the VGA wand game. Sequences the screen phases

---
 rtl/game_pkg.sv | 34 +++
 rtl/sec_prescaler.sv | 29 ++
 rtl/game_phase_sequencer.sv | 125 ++++++++++++
 tb/tb_game_phase_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared phase encoding and helpers for the wand game flow controller.
// Phase values are fixed so screen logic elsewhere can decode them directly.
package game_pkg;

    localparam int PH_W = 3;

    typedef enum logic [PH_W-1:0] {
        PH_LOGO   = 3'd0,
        PH_READY  = 3'd1,
        PH_PLAY   = 3'd2,
        PH_TUP    = 3'd3,
        PH_LEADER = 3'd4
    } phase_e;

    function automatic logic [7:0] phase_secs(
        input phase_e     ph,
        input logic [7:0] rdy,
        input logic [7:0] ply,
        input logic [7:0] tup,
        input logic [7:0] ldr
    );
        logic [7:0] s;
        s = 8'd0;
        case (ph)
            PH_READY:  s = rdy;
            PH_PLAY:   s = ply;
            PH_TUP:    s = tup;
            PH_LEADER: s = ldr;
            default:   s = 8'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second tick generator; counts 0..CLK_HZ-1 and pulses on the last count.
// Shared with the on-screen timer block.
module sec_prescaler #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clock,
    input  logic resetn,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_phase_sequencer.sv
// Game-flow controller: LOGO -> GET_READY -> PLAY -> TIMES_UP -> LEADERBOARD.
// Drives one-hot screen selects, score gating and a per-phase seconds countdown.
module game_phase_sequencer
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned READY_SEC   = 5,
    parameter int unsigned PLAY_SEC    = 60,
    parameter int unsigned TIMESUP_SEC = 3,
    parameter int unsigned LEADER_SEC  = 10
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       abort,
    input  logic       two_player_sel,
    output logic       logo,
    output logic       get_ready,
    output logic       play,
    output logic       times_up,
    output logic       leaderboard,
    output logic       two_player_mode,
    output logic       score_enable,
    output logic       score_clear,
    output logic       end_of_game,
    output logic [7:0] seconds_left,
    output logic       sec_tick
);

    if (READY_SEC == 0 || PLAY_SEC == 0 || TIMESUP_SEC == 0 || LEADER_SEC == 0 ||
        READY_SEC > 255 || PLAY_SEC > 255 || TIMESUP_SEC > 255 || LEADER_SEC > 255)
    begin : g_cfg_err
        $error("game_phase_sequencer: every *_SEC must be in 1..255");
    end

    localparam logic [7:0] RDY8 = 8'(READY_SEC);
    localparam logic [7:0] PLY8 = 8'(PLAY_SEC);
    localparam logic [7:0] TUP8 = 8'(TIMESUP_SEC);
    localparam logic [7:0] LDR8 = 8'(LEADER_SEC);

    phase_e     state_q, state_d;
    logic [7:0] secs_q, secs_d;
    logic       start_q;
    logic       rise, tick, expire, entering, clr, new_game;
    logic       logo_q, ready_q, play_q, tup_q, ldr_q;
    logic       mode_q, en_q, sclr_q, eog_q;

    sec_prescaler #(.CLK_HZ(CLK_HZ)) u_pre (
        .clock  (clock),
        .resetn (resetn),
        .clr    (clr),
        .tick   (tick)
    );

    assign rise     = start & ~start_q;
    assign expire   = tick & (secs_q == 8'd1);
    assign entering = (state_d != state_q);
    assign new_game = (state_q == PH_LOGO) & (state_d == PH_READY);
    // Holding the prescaler in LOGO makes every phase start from a full second.
    assign clr      = entering | (state_q == PH_LOGO);

    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_LOGO:   if (!abort && rise) state_d = PH_READY;
            PH_READY:  if (expire) state_d = PH_PLAY;
            PH_PLAY:   if (expire) state_d = PH_TUP;
            PH_TUP:    if (expire) state_d = PH_LEADER;
            PH_LEADER: if (expire || rise) state_d = PH_LOGO;
            default:   state_d = PH_LOGO;
        endcase
        if (abort && state_q != PH_LOGO) state_d = PH_LOGO;
    end

    always_comb begin
        secs_d = secs_q;
        if (entering)
            secs_d = phase_secs(state_d, RDY8, PLY8, TUP8, LDR8);
        else if (tick && state_q != PH_LOGO)
            secs_d = secs_q - 8'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= PH_LOGO;
            secs_q  <= 8'd0;
            start_q <= 1'b1;
            logo_q  <= 1'b1;
            ready_q <= 1'b0;
            play_q  <= 1'b0;
            tup_q   <= 1'b0;
            ldr_q   <= 1'b0;
            mode_q  <= 1'b0;
            en_q    <= 1'b0;
            sclr_q  <= 1'b0;
            eog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
            start_q <= start;
            logo_q  <= (state_d == PH_LOGO);
            ready_q <= (state_d == PH_READY);
            play_q  <= (state_d == PH_PLAY);
            tup_q   <= (state_d == PH_TUP);
            ldr_q   <= (state_d == PH_LEADER);
            en_q    <= (state_d == PH_PLAY);
            sclr_q  <= new_game;
            eog_q   <= (state_q == PH_PLAY) & (state_d == PH_TUP);
            if (new_game) mode_q <= two_player_sel;
        end
    end

    assign logo            = logo_q;
    assign get_ready       = ready_q;
    assign play            = play_q;
    assign times_up        = tup_q;
    assign leaderboard     = ldr_q;
    assign two_player_mode = mode_q;
    assign score_enable    = en_q;
    assign score_clear     = sclr_q;
    assign end_of_game     = eog_q;
    assign seconds_left    = secs_q;
    assign sec_tick        = tick & (state_q != PH_LOGO);

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Bench for game_phase_sequencer: table vectors, directed corner cases and
// randomized traffic against a cycle-count model of the phase schedule.
module tb_game_phase_sequencer;

    localparam int CLK = 10;
    localparam int RS  = 2;
    localparam int PS  = 3;
    localparam int TS  = 1;
    localparam int LS  = 2;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       two_player_sel = 1'b0;
    logic       logo, get_ready, play, times_up, leaderboard;
    logic       two_player_mode, score_enable, score_clear, end_of_game;
    logic [7:0] seconds_left;
    logic       sec_tick;

    game_phase_sequencer #(
        .CLK_HZ(CLK), .READY_SEC(RS), .PLAY_SEC(PS),
        .TIMESUP_SEC(TS), .LEADER_SEC(LS)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .start           (start),
        .abort           (abort),
        .two_player_sel  (two_player_sel),
        .logo            (logo),
        .get_ready       (get_ready),
        .play            (play),
        .times_up        (times_up),
        .leaderboard     (leaderboard),
        .two_player_mode (two_player_mode),
        .score_enable    (score_enable),
        .score_clear     (score_clear),
        .end_of_game     (end_of_game),
        .seconds_left    (seconds_left),
        .sec_tick        (sec_tick)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc  = 0;

    // Model: phase index plus cycles elapsed inside the phase.
    int   secs_of[5] = '{0, RS, PS, TS, LS};
    int   m_ph, m_cyc;
    logic m_prev, m_mode, m_clr, m_eog;

    typedef struct {
        logic       s;
        logic       a;
        logic       sl;
        logic [4:0] scr;
        logic       clr;
        logic [7:0] secs;
    } vec_t;

    vec_t tbl[5];

    int cnt_ph[5];
    int cnt_eog, cnt_tick_play, cnt_en;

    task automatic check(input string nm, input logic [17:0] got,
                         input logic [17:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting", nm);
    endtask

    function automatic logic [17:0] dut_vec();
        return {leaderboard, times_up, play, get_ready, logo,
                two_player_mode, score_enable, score_clear,
                end_of_game, sec_tick, seconds_left};
    endfunction

    function automatic logic [17:0] m_vec();
        logic [4:0] oh;
        logic       tk;
        logic [7:0] sc;
        oh = 5'd1 << m_ph;
        tk = (m_ph != 0) && (m_cyc % CLK == CLK - 1);
        sc = (m_ph == 0) ? 8'd0 : 8'(secs_of[m_ph] - m_cyc / CLK);
        return {oh, m_mode, (m_ph == 2), m_clr, m_eog, tk, sc};
    endfunction

    task automatic model_reset();
        m_ph   = 0;
        m_cyc  = 0;
        m_prev = 1'b1;
        m_mode = 1'b0;
        m_clr  = 1'b0;
        m_eog  = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic sl);
        logic rise;
        rise  = s && !m_prev;
        m_clr = 1'b0;
        m_eog = 1'b0;
        if (a && m_ph != 0) begin
            m_ph = 0; m_cyc = 0;
        end else if (m_ph == 0) begin
            if (!a && rise) begin
                m_ph = 1; m_cyc = 0; m_mode = sl; m_clr = 1'b1;
            end
        end else if (m_ph == 4 && rise) begin
            m_ph = 0; m_cyc = 0;
        end else if (m_cyc == secs_of[m_ph] * CLK - 1) begin
            if (m_ph == 2) m_eog = 1'b1;
            m_ph  = (m_ph + 1) % 5;
            m_cyc = 0;
        end else begin
            m_cyc++;
        end
        m_prev = s;
    endtask

    task automatic step(input logic s, input logic a, input logic sl);
        start = s;
        abort = a;
        two_player_sel = sl;
        @(posedge clock);
        model_step(s, a, sl);
        #1;
        ncyc++;
        check($sformatf("cycle%0d", ncyc), dut_vec(), m_vec());
    endtask

    task automatic acc();
        if (logo)        cnt_ph[0]++;
        if (get_ready)   cnt_ph[1]++;
        if (play)        cnt_ph[2]++;
        if (times_up)    cnt_ph[3]++;
        if (leaderboard) cnt_ph[4]++;
        if (end_of_game) cnt_eog++;
        if (score_enable) cnt_en++;
        if (play && sec_tick) cnt_tick_play++;
    endtask

    localparam logic [17:0] RST_VEC = {5'b00001, 13'd0};

    initial begin
        logic found, did, sl, s, a;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 5'b00001, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 5'b00001, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 5'b00010, 1'b1, 8'd2};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 5'b00010, 1'b0, 8'd2};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 5'b00010, 1'b0, 8'd2};

        start  = 1'b1;
        resetn = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", dut_vec(), RST_VEC);
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(tbl[i].s, tbl[i].a, tbl[i].sl);
            check($sformatf("tbl%0d_scr", i),
                  {13'd0, leaderboard, times_up, play, get_ready, logo},
                  {13'd0, tbl[i].scr});
            check($sformatf("tbl%0d_clr", i), {17'd0, score_clear},
                  {17'd0, tbl[i].clr});
            check($sformatf("tbl%0d_secs", i), {10'd0, seconds_left},
                  {10'd0, tbl[i].secs});
        end

        step(1'b0, 1'b1, 1'b0);
        check("abort_ready_logo", {17'd0, logo}, 18'd1);

        // Full game with mode select toggling during PLAY.
        for (int k = 0; k < 5; k++) cnt_ph[k] = 0;
        cnt_eog = 0; cnt_tick_play = 0; cnt_en = 0;
        step(1'b1, 1'b0, 1'b1);
        acc();
        for (int i = 0; i < 80; i++) begin
            sl = play ? 1'(i % 2) : 1'b1;
            step(1'b0, 1'b0, sl);
            acc();
        end
        check("game_ready_len",  18'(cnt_ph[1]), 18'd20);
        check("game_play_len",   18'(cnt_ph[2]), 18'd30);
        check("game_tup_len",    18'(cnt_ph[3]), 18'd10);
        check("game_leader_len", 18'(cnt_ph[4]), 18'd20);
        check("game_eog_count",  18'(cnt_eog), 18'd1);
        check("game_play_ticks", 18'(cnt_tick_play), 18'd3);
        check("game_enable_len", 18'(cnt_en), 18'd30);
        check("game_end_logo",   {17'd0, logo}, 18'd1);
        check("game_mode_held",  {17'd0, two_player_mode}, 18'd1);

        // Abort on the final PLAY tick beats the expiry.
        step(1'b1, 1'b0, 1'b0);
        check("mode_new_game", {17'd0, two_player_mode}, 18'd0);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (play && sec_tick && seconds_left == 8'd1) found = 1'b1;
            else step(1'b0, 1'b0, 1'b0);
        end
        if (!found) tmo("play_last_tick");
        step(1'b0, 1'b1, 1'b0);
        check("abort_tick_logo", {17'd0, logo}, 18'd1);
        check("abort_tick_eog",  {17'd0, end_of_game}, 18'd0);
        check("abort_tick_secs", {10'd0, seconds_left}, 18'd0);
        step(1'b0, 1'b0, 1'b0);
        check("abort_no_late_eog", {17'd0, end_of_game}, 18'd0);

        // Start ignored in PLAY; start skips LEADERBOARD.
        step(1'b1, 1'b0, 1'b0);
        found = 1'b0;
        did   = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (leaderboard) found = 1'b1;
            else if (play && !did) begin
                step(1'b1, 1'b0, 1'b0);
                did = 1'b1;
                check("start_in_play", {17'd0, play}, 18'd1);
            end else step(1'b0, 1'b0, 1'b0);
        end
        if (!found) tmo("reach_leader");
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("leader_skip", {16'd0, leaderboard, logo}, 18'd1);

        // LOGO: abort blocks start; held start does not retrigger.
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("logo_abort_start", {17'd0, logo}, 18'd1);
        step(1'b1, 1'b0, 1'b0);
        check("logo_held_start", {17'd0, logo}, 18'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("logo_restart", {17'd0, get_ready}, 18'd1);

        // Asynchronous reset in the middle of PLAY.
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (play && seconds_left == 8'd2) found = 1'b1;
            else step(1'b0, 1'b0, 1'b0);
        end
        if (!found) tmo("reach_play");
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", dut_vec(), RST_VEC);
        model_reset();
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Randomized traffic.
        s = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) s = ~s;
            a  = ($urandom_range(0, 149) == 0);
            sl = 1'($urandom);
            step(s, a, sl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
